// File: rtl/riscv_sc_core.sv
// Single-cycle RV32I-subset core: controller (main + ALU decoder), datapath
// with PC logic, immediate extender, ALU and a 32x32 register file.
// Instruction and data memories are external; one instruction per clock.

// Register file: two combinational read ports, one synchronous write port.
module riscv_sc_regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_CLK,
  input  logic            i_Reset,
  input  logic            i_WE,
  input  logic [4:0]      i_A1,
  input  logic [4:0]      i_A2,
  input  logic [4:0]      i_A3,
  input  logic [XLEN-1:0] i_WD,
  output logic [XLEN-1:0] o_RD1,
  output logic [XLEN-1:0] o_RD2
);

  logic [XLEN-1:0] register [32];

  // Clear every register on reset; write rd on the rising edge, never x0.
  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        register[i] <= '0;
      end
    end else if (i_WE && (i_A3 != 5'd0)) begin
      register[i_A3] <= i_WD;
    end
  end

  assign o_RD1 = (i_A1 == 5'd0) ? '0 : register[i_A1];
  assign o_RD2 = (i_A2 == 5'd0) ? '0 : register[i_A2];

endmodule

// Controller: main decoder plus ALU decoder, and the PC-source decision.
module riscv_sc_controller (
  input  logic [6:0] i_Op,
  input  logic [2:0] i_Funct3,
  input  logic       i_Funct7b5,
  input  logic       i_Zero,
  output logic       o_RegWrite,
  output logic       o_MemWrite,
  output logic       o_ALUSrc,
  output logic       o_PCSrc,
  output logic [1:0] o_ResultSrc,
  output logic [2:0] o_ImmSrc,
  output logic [2:0] o_ALUControl
);

  logic [1:0] alu_op;
  logic       branch_eq;
  logic       branch_ne;
  logic       jump;
  logic       is_rtype;
  logic       funct_ok;

  assign is_rtype = (i_Op == 7'b0110011);
  // Only add/sub, slt, or and and exist for the R-type and I-type ALU groups.
  assign funct_ok = (i_Funct3 == 3'b000) || (i_Funct3 == 3'b010) ||
                    (i_Funct3 == 3'b110) || (i_Funct3 == 3'b111);

  // Main decoder: opcode to datapath control; unknown opcodes behave as nops.
  always_comb begin
    o_RegWrite  = 1'b0;
    o_MemWrite  = 1'b0;
    o_ALUSrc    = 1'b0;
    o_ResultSrc = 2'b00;
    o_ImmSrc    = 3'b000;
    alu_op      = 2'b00;
    branch_eq   = 1'b0;
    branch_ne   = 1'b0;
    jump        = 1'b0;
    case (i_Op)
      7'b0000011: begin // lw
        o_RegWrite  = 1'b1;
        o_ALUSrc    = 1'b1;
        o_ResultSrc = 2'b01;
        o_ImmSrc    = 3'b000;
      end
      7'b0100011: begin // sw
        o_MemWrite = 1'b1;
        o_ALUSrc   = 1'b1;
        o_ImmSrc   = 3'b001;
      end
      7'b0110011: begin // R-type
        o_RegWrite = funct_ok;
        alu_op     = 2'b10;
      end
      7'b0010011: begin // I-type ALU
        o_RegWrite = funct_ok;
        o_ALUSrc   = 1'b1;
        o_ImmSrc   = 3'b000;
        alu_op     = 2'b10;
      end
      7'b1100011: begin // beq / bne
        o_ImmSrc  = 3'b010;
        alu_op    = 2'b01;
        branch_eq = (i_Funct3 == 3'b000);
        branch_ne = (i_Funct3 == 3'b001);
      end
      7'b1101111: begin // jal
        o_RegWrite  = 1'b1;
        o_ImmSrc    = 3'b011;
        o_ResultSrc = 2'b10;
        jump        = 1'b1;
      end
      7'b0110111: begin // lui
        o_RegWrite  = 1'b1;
        o_ImmSrc    = 3'b100;
        o_ResultSrc = 2'b11;
      end
      default: ;
    endcase
  end

  // ALU decoder: funct3/funct7 select the operation for ALU-group opcodes.
  always_comb begin
    o_ALUControl = 3'b000;
    case (alu_op)
      2'b01: o_ALUControl = 3'b001;
      2'b10: begin
        case (i_Funct3)
          3'b000:  o_ALUControl = (is_rtype && i_Funct7b5) ? 3'b001 : 3'b000;
          3'b010:  o_ALUControl = 3'b101;
          3'b110:  o_ALUControl = 3'b011;
          3'b111:  o_ALUControl = 3'b010;
          default: o_ALUControl = 3'b000;
        endcase
      end
      default: o_ALUControl = 3'b000;
    endcase
  end

  assign o_PCSrc = (branch_eq && i_Zero) || (branch_ne && !i_Zero) || jump;

endmodule

// Datapath: PC register, immediate extender, register file, ALU, result mux.
module riscv_sc_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_CLK,
  input  logic            i_Reset,
  input  logic [31:7]     i_Instr,
  input  logic [XLEN-1:0] i_ReadData,
  input  logic            i_RegWrite,
  input  logic            i_ALUSrc,
  input  logic            i_PCSrc,
  input  logic [1:0]      i_ResultSrc,
  input  logic [2:0]      i_ImmSrc,
  input  logic [2:0]      i_ALUControl,
  output logic            o_Zero,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_ALUResult,
  output logic [XLEN-1:0] o_WriteData
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] result;

  // Program counter register.
  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_plus4  = pc_q + XLEN'(4);
  assign pc_target = pc_q + imm_ext;
  assign pc_d      = i_PCSrc ? pc_target : pc_plus4;

  // Immediate extender: I, S, B, J and U formats.
  always_comb begin
    imm_ext = '0;
    case (i_ImmSrc)
      3'b000:  imm_ext = {{(XLEN-12){i_Instr[31]}}, i_Instr[31:20]};
      3'b001:  imm_ext = {{(XLEN-12){i_Instr[31]}}, i_Instr[31:25], i_Instr[11:7]};
      3'b010:  imm_ext = {{(XLEN-13){i_Instr[31]}}, i_Instr[31], i_Instr[7],
                          i_Instr[30:25], i_Instr[11:8], 1'b0};
      3'b011:  imm_ext = {{(XLEN-21){i_Instr[31]}}, i_Instr[31], i_Instr[19:12],
                          i_Instr[20], i_Instr[30:21], 1'b0};
      3'b100:  imm_ext = {{(XLEN-32){i_Instr[31]}}, i_Instr[31:12], 12'b0};
      default: imm_ext = '0;
    endcase
  end

  riscv_sc_regfile #(
    .XLEN(XLEN)
  ) du1_regfile (
    .i_CLK   (i_CLK),
    .i_Reset (i_Reset),
    .i_WE    (i_RegWrite),
    .i_A1    (i_Instr[19:15]),
    .i_A2    (i_Instr[24:20]),
    .i_A3    (i_Instr[11:7]),
    .i_WD    (result),
    .o_RD1   (src_a),
    .o_RD2   (rd2)
  );

  assign src_b = i_ALUSrc ? imm_ext : rd2;

  // ALU: add, sub, and, or, signed set-less-than.
  always_comb begin
    alu_result = '0;
    case (i_ALUControl)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign o_Zero = (alu_result == '0);

  // Writeback mux; the fourth leg carries the U-immediate straight through for lui.
  always_comb begin
    result = alu_result;
    case (i_ResultSrc)
      2'b00:   result = alu_result;
      2'b01:   result = i_ReadData;
      2'b10:   result = pc_plus4;
      default: result = imm_ext;
    endcase
  end

  assign o_PC        = pc_q;
  assign o_ALUResult = alu_result;
  assign o_WriteData = rd2;

endmodule

// Top level: wires controller and datapath; store enable is gated by reset.
module riscv_sc_core #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_CLK,
  input  logic            i_Reset,
  input  logic [31:0]     i_Instr,
  input  logic [XLEN-1:0] i_ReadData,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_ALUResult,
  output logic            o_MemWrite,
  output logic [XLEN-1:0] o_WriteData
);

  logic       reg_write;
  logic       mem_write;
  logic       alu_src;
  logic       pc_src;
  logic       zero;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic [2:0] alu_control;

  riscv_sc_controller controller (
    .i_Op         (i_Instr[6:0]),
    .i_Funct3     (i_Instr[14:12]),
    .i_Funct7b5   (i_Instr[30]),
    .i_Zero       (zero),
    .o_RegWrite   (reg_write),
    .o_MemWrite   (mem_write),
    .o_ALUSrc     (alu_src),
    .o_PCSrc      (pc_src),
    .o_ResultSrc  (result_src),
    .o_ImmSrc     (imm_src),
    .o_ALUControl (alu_control)
  );

  riscv_sc_datapath #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) datapath (
    .i_CLK        (i_CLK),
    .i_Reset      (i_Reset),
    .i_Instr      (i_Instr[31:7]),
    .i_ReadData   (i_ReadData),
    .i_RegWrite   (reg_write),
    .i_ALUSrc     (alu_src),
    .i_PCSrc      (pc_src),
    .i_ResultSrc  (result_src),
    .i_ImmSrc     (imm_src),
    .i_ALUControl (alu_control),
    .o_Zero       (zero),
    .o_PC         (o_PC),
    .o_ALUResult  (o_ALUResult),
    .o_WriteData  (o_WriteData)
  );

  assign o_MemWrite = mem_write && i_Reset;

endmodule

// File: tb/tb_riscv_sc_core.sv
// Bench for riscv_sc_core: directed programs plus random programs, checked
// against an instruction-level reference model of the RV32I subset.
module tb_riscv_sc_core;

  logic        i_CLK = 1'b0;
  logic        i_Reset;
  logic [31:0] i_Instr;
  logic [31:0] i_ReadData;
  logic [31:0] o_PC;
  logic [31:0] o_ALUResult;
  logic        o_MemWrite;
  logic [31:0] o_WriteData;

  logic [31:0] imem   [256];
  logic [31:0] dmem   [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;
  localparam logic [6:0] OP_U = 7'b0110111;

  riscv_sc_core #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .i_CLK       (i_CLK),
    .i_Reset     (i_Reset),
    .i_Instr     (i_Instr),
    .i_ReadData  (i_ReadData),
    .o_PC        (o_PC),
    .o_ALUResult (o_ALUResult),
    .o_MemWrite  (o_MemWrite),
    .o_WriteData (o_WriteData)
  );

  always #5 i_CLK = ~i_CLK;

  assign i_Instr    = imem[o_PC[9:2]];
  assign i_ReadData = dmem[o_ALUResult[9:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_S};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    int s;
    s = 32 - bits;
    return 32'($signed(v << s) >>> s);
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return sx({20'b0, ins[31:20]}, 12);
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return sx({20'b0, ins[31:25], ins[11:7]}, 12);
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return sx({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return sx({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
  endfunction

  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic sub,
                                         input logic [31:0] a, input logic [31:0] b,
                                         output logic ok);
    ok = 1'b1;
    case (f3)
      3'b000:  return sub ? a - b : a + b;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: begin ok = 1'b0; return 32'd0; end
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, val, npc, addr;
    logic        wr;
    ins = imem[m_pc[9:2]];
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    wr  = 1'b0;
    val = 32'h0;
    npc = m_pc + 32'd4;
    case (ins[6:0])
      OP_L: begin addr = a + imm_i(ins); val = m_dmem[addr[9:2]]; wr = 1'b1; end
      OP_S: begin addr = a + imm_s(ins); m_dmem[addr[9:2]] = b; end
      OP_R: val = alu_op(ins[14:12], ins[30], a, b, wr);
      OP_I: val = alu_op(ins[14:12], 1'b0, a, imm_i(ins), wr);
      OP_B: if ((ins[14:12] == 3'b000 && a == b) || (ins[14:12] == 3'b001 && a != b))
              npc = m_pc + imm_b(ins);
      OP_J: begin val = m_pc + 32'd4; wr = 1'b1; npc = m_pc + imm_j(ins); end
      OP_U: begin val = {ins[31:12], 12'b0}; wr = 1'b1; end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = val;
    m_pc = npc;
  endtask

  // One clock: check bus outputs before the edge, model the memory write,
  // step the model, then check the PC.
  task automatic cycle();
    logic [31:0] ins, a, b, wa, wd;
    logic        we;
    if (i_CLK) @(negedge i_CLK);
    ins = imem[m_pc[9:2]];
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    chk("memwrite", {31'b0, o_MemWrite}, {31'b0, ins[6:0] == OP_S});
    if (ins[6:0] == OP_L) chk("lw_addr", o_ALUResult, a + imm_i(ins));
    if (ins[6:0] == OP_S) begin
      chk("sw_addr", o_ALUResult, a + imm_s(ins));
      chk("sw_data", o_WriteData, b);
    end
    we = o_MemWrite;
    wa = o_ALUResult;
    wd = o_WriteData;
    @(posedge i_CLK);
    #1;
    if (we) dmem[wa[9:2]] = wd;
    model_step();
    chk("pc", o_PC, m_pc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [31:0] xreg(input int n);
    return dut.datapath.du1_regfile.register[n];
  endfunction

  task automatic start_prog();
    model_reset();
    @(posedge i_CLK);
    #1 i_Reset = 1'b1;
  endtask

  task automatic end_prog();
    int bad;
    for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), xreg(i), m_regs[i]);
    bad = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== m_dmem[i]) bad++;
    chk("dmem_words_differing", bad, 0);
    for (int i = 0; i < 256; i++) m_dmem[i] = dmem[i];
    @(negedge i_CLK);
    i_Reset = 1'b0;
  endtask

  task automatic put(input int addr, input logic [31:0] ins);
    imem[addr / 4] = ins;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0] f3s [4];
    logic [2:0] bf3 [3];
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
    f3s = '{3'b000, 3'b010, 3'b110, 3'b111};
    bf3 = '{3'b000, 3'b001, 3'b100};
    rd  = 5'($urandom_range(0, 15));
    rs1 = 5'($urandom_range(0, 15));
    rs2 = 5'($urandom_range(0, 15));
    imm = $urandom;
    case ($urandom_range(0, 10))
      0, 1:  return enc_r({1'b0, 1'($urandom_range(0, 1)), 5'b0}, rs2, rs1,
                          f3s[$urandom_range(0, 3)], rd);
      2, 3:  return enc_i(imm, rs1, f3s[$urandom_range(0, 3)], rd, OP_I);
      4:     return enc_i(imm, rs1, 3'b010, rd, OP_L);
      5:     return enc_s(imm, rs2, rs1);
      6:     return enc_b(32'(($urandom_range(0, 15) - 8) * 4), rs2, rs1,
                          bf3[$urandom_range(0, 2)]);
      7:     return enc_j(32'(($urandom_range(0, 31) - 16) * 4), rd);
      8:     return {imm[31:12], rd, OP_U};
      9:     return enc_r(7'b0, rs2, rs1, 3'b001, rd);
      default: return {imm[31:7], 7'b1110011};
    endcase
  endfunction

  initial begin
    int nz;
    i_Reset = 1'b1;
    clear_imem();
    for (int i = 0; i < 256; i++) begin
      dmem[i]   = $urandom;
      m_dmem[i] = dmem[i];
    end
    // A store sits at the reset PC so an ungated write enable would show.
    put(0, enc_s(96, 5'd0, 5'd0));
    #2 i_Reset = 1'b0;
    repeat (2) @(negedge i_CLK);
    chk("rst_pc", o_PC, 32'h0);
    chk("rst_memwrite", {31'b0, o_MemWrite}, 32'h0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (xreg(i) !== 32'h0) nz++;
    chk("rst_nonzero_regs", nz, 0);

    // Program A: arithmetic, logic, slt, memory, branches, x0.
    clear_imem();
    put(32'h00, enc_i(5, 0, 3'b000, 2, OP_I));
    put(32'h04, enc_i(12, 0, 3'b000, 3, OP_I));
    put(32'h08, enc_r(7'h00, 3, 2, 3'b000, 7));
    put(32'h0C, enc_r(7'h20, 2, 7, 3'b000, 4));
    put(32'h10, enc_i(-3, 0, 3'b000, 5, OP_I));
    put(32'h14, enc_r(7'h00, 2, 5, 3'b010, 6));
    put(32'h18, enc_i(32'h7FF, 0, 3'b110, 8, OP_I));
    put(32'h1C, enc_r(7'h00, 3, 5, 3'b111, 10));
    put(32'h20, enc_r(7'h00, 2, 5, 3'b110, 11));
    put(32'h24, enc_i(-2, 5, 3'b010, 12, OP_I));
    put(32'h28, enc_s(96, 7, 0));
    put(32'h2C, enc_i(96, 0, 3'b010, 9, OP_L));
    put(32'h30, enc_i(9, 0, 3'b000, 0, OP_I));
    put(32'h34, enc_b(8, 2, 2, 3'b000));
    put(32'h38, enc_i(1, 0, 3'b000, 13, OP_I));
    put(32'h3C, enc_b(8, 3, 2, 3'b000));
    put(32'h40, enc_b(8, 3, 2, 3'b001));
    put(32'h44, enc_i(2, 0, 3'b000, 13, OP_I));
    put(32'h48, enc_i(7, 0, 3'b000, 14, OP_I));
    start_prog();
    run(1);
    chk("pc_first_edge", o_PC, 32'h4);
    run(3);
    chk("pc_after_4", o_PC, 32'h10);
    chk("add_x7", xreg(7), 32'd17);
    chk("sub_x4", xreg(4), 32'd12);
    run(6);
    @(negedge i_CLK);
    chk("sw_we", {31'b0, o_MemWrite}, 32'h1);
    chk("sw_addr96", o_ALUResult, 32'd96);
    chk("sw_data17", o_WriteData, 32'd17);
    run(7);
    chk("pc_end_a", o_PC, 32'h4C);
    chk("slt_x6", xreg(6), 32'd1);
    chk("ori_x8", xreg(8), 32'd2047);
    chk("and_x10", xreg(10), 32'd12);
    chk("or_x11", xreg(11), 32'hFFFF_FFFD);
    chk("slti_x12", xreg(12), 32'd1);
    chk("lw_x9", xreg(9), 32'd17);
    chk("x0_zero", xreg(0), 32'd0);
    chk("skipped_x13", xreg(13), 32'd0);
    chk("bne_x14", xreg(14), 32'd7);
    end_prog();

    // Program B: unsupported nops then a backward jal.
    clear_imem();
    put(32'h18, enc_i(3, 0, 3'b000, 15, OP_I));
    put(32'h20, enc_j(-8, 1));
    start_prog();
    run(9);
    chk("jal_pc", o_PC, 32'h18);
    chk("jal_x1", xreg(1), 32'h24);
    chk("jal_x15", xreg(15), 32'd3);
    end_prog();

    // Random programs.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 256; i++) imem[i] = rand_instr();
      start_prog();
      run(150);
      if (p == 2) begin
        // Reset between edges must clear state without waiting for a clock.
        #2 i_Reset = 1'b0;
        #1;
        chk("midrst_pc", o_PC, 32'h0);
        chk("midrst_memwrite", {31'b0, o_MemWrite}, 32'h0);
        nz = 0;
        for (int i = 0; i < 32; i++) if (xreg(i) !== 32'h0) nz++;
        chk("midrst_nonzero_regs", nz, 0);
        model_reset();
      end else begin
        end_prog();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_sc_core.md
Name: riscv_sc_core

Overview:
- 32-bit single-cycle RV32I-subset processor core: controller, ALU decoder, datapath, 32x32 register file, PC logic and immediate extender.
- Instructions arrive from an external combinational instruction memory, addressed by o_PC[9:2].
- Data accesses go to an external word-addressed data memory, addressed by o_ALUResult[9:2]. That memory writes synchronously and reads combinationally.
- One instruction completes per clock.

Parameters:
- XLEN, 32, datapath and register width.
- RESET_PC, 32'h0000_0000, PC value loaded during reset.

Ports:
- i_CLK  in  1  core clock; all state updates on the rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_Instr  in  32  instruction fetched at o_PC.
- i_ReadData  in  32  data-memory read word at o_ALUResult.
- o_PC  out  32  current program counter.
- o_ALUResult  out  32  ALU output; used as the data-memory address for lw/sw.
- o_MemWrite  out  1  data-memory write enable; high only for sw.
- o_WriteData  out  32  store data, equal to rs2.

Behaviour:
- Reset (i_Reset=0, asynchronous):
  - PC <= RESET_PC.
  - All 32 registers cleared to 0.
  - o_MemWrite is forced to 0 while reset is asserted.
- On deassertion, the first rising edge executes the instruction at RESET_PC.
- Supported opcodes, all executing in one cycle:
  - lw (0000011): rd <= i_ReadData; address = rs1 + sext(imm[31:20]).
  - sw (0100011): o_MemWrite=1; address = rs1 + sext({imm[31:25],imm[11:7]}); o_WriteData = rs2.
  - R-type (0110011): add, sub (funct7[5]=1), and, or, slt (signed).
  - I-type ALU (0010011): addi, andi, ori, slti. No shifts; funct7 bit ignored.
  - beq (1100011, funct3=000): if rs1==rs2 then PC <= PC + sext(B-imm). B-imm is a 13-bit, even offset.
  - bne (funct3=001): branches when rs1!=rs2.
  - jal (1101111): rd <= PC+4; PC <= PC + sext(J-imm), a 21-bit offset.
  - lui (0110111): rd <= {imm[31:12],12'b0}.
- All other instructions: PC <= PC+4, with no register write and no memory write.
- ALUControl encoding, 3 bits: 000 add, 001 sub, 010 and, 011 or, 101 slt.
  - lw, sw and jal use add.
  - beq and bne use sub; the branch decision uses the Zero flag.
- Result mux (ResultSrc): 00 ALU result, 01 i_ReadData, 10 PC+4.
- lui: writes the U-immediate (ImmSrc U) through a pass-through path.
- Register file:
  - Two combinational read ports and one write port, written on the rising edge when RegWrite=1.
  - x0 always reads 0; writes to x0 are ignored.
  - Read-during-write on the same edge returns the old value.
- Default next PC is PC+4. Addition wraps modulo 2^32.
- The register array is named `register` and the register-file instance is reachable as datapath.du1_regfile, so a bench can hierarchically read register[n].
- o_ALUResult and o_WriteData are combinational from the current instruction and register state.
- The store reaches data memory on the same rising edge that advances the PC.
- Reset asserted mid-program: the PC and registers clear immediately, regardless of the clock.

Test Plan:
- Hold i_Reset=0 for 2 cycles, then release -> o_PC=0, all registers 0, o_MemWrite=0 during reset; o_PC=4 after the first edge.
- Run addi x2,x0,5; addi x3,x0,12; add x7,x2,x3; sub x4,x7,x2 -> x7=17, x4=12, PC=0x10.
- Run and/or/slt/slti with a negative operand (x5=-3): slt x6,x5,x2 -> x6=1; ori x8,x0,0x7FF -> x8=2047.
- Run sw x7,96(x0) then lw x9,96(x0) -> first instruction: o_MemWrite=1, o_ALUResult=96, o_WriteData=17; afterwards x9=17.
- beq taken with offset +8 and not taken; bne taken -> PC skips exactly one instruction when taken, otherwise PC+4.
- jal x1,-8 from PC=0x20 -> x1=0x24, PC=0x18.
- Addi to x0 -> x0 stays 0.
